// File: rtl/mem_burst_reader_if.sv
// Command, RAM-master and read-stream signals of mem_burst_reader.
// slave is the burst engine side, master the side that drives it.
interface mem_burst_reader_if #(
  parameter int WORDS = 256,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(WORDS);

  logic             start;
  logic             op;
  logic [AW-1:0]    start_addr;
  logic [AW:0]      len;
  logic [WIDTH-1:0] fill_data;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_addr;
  logic             mem_wen;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport slave (
    input  start, op, start_addr, len, fill_data,
    input  mem_rdata, out_ready,
    output busy, done,
    output mem_addr, mem_wen, mem_wdata,
    output out_valid, out_data, out_last
  );

  modport master (
    output start, op, start_addr, len, fill_data,
    output mem_rdata, out_ready,
    input  busy, done,
    input  mem_addr, mem_wen, mem_wdata,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst engine for a 1-cycle-latency single-port RAM: streams a
// read burst through a 3-entry FIFO or fills a range with a constant.
module mem_burst_reader #(
  parameter int WORDS = 256,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_burst_reader_if.slave  bus
);
  localparam int AW = $clog2(WORDS);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FILL,
    FLUSH,
    DONE
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    mem_addr_q;
  logic             mem_wen_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [LW-1:0]    rem_q;

  logic             rd_en_q;
  logic             rd_last_q;
  logic             rv_q;
  logic             rv_last_q;

  logic [WIDTH-1:0] fifo_data_q [3];
  logic             fifo_last_q [3];
  logic [1:0]       wr_ptr_q;
  logic [1:0]       rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  logic             pop;
  logic             push;
  logic [2:0]       occ;
  logic             issue_ok;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read may issue next cycle only if every word already owed
  // to the FIFO, plus that read, still fits in three entries.
  always_comb begin
    pop      = (count_q != 2'd0) && bus.out_ready;
    push     = rv_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    occ      = {1'b0, count_d} + {2'b00, rd_en_q};
    issue_ok = (rem_q != '0) && (occ < 3'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      rem_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      rv_q        <= 1'b0;
      rv_last_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      rv_q      <= rd_en_q;
      rv_last_q <= rd_last_q;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= count_d;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
        fifo_last_q[wr_ptr_q] <= rv_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              mem_addr_q <= bus.start_addr;
              rem_q      <= bus.len - LW'(1);
              if (bus.op) begin
                state_q     <= FILL;
                mem_wen_q   <= 1'b1;
                mem_wdata_q <= bus.fill_data;
              end else begin
                state_q   <= READ;
                rd_en_q   <= 1'b1;
                rd_last_q <= (bus.len == LW'(1));
              end
            end
          end
        end
        READ: begin
          if (rem_q == '0) begin
            state_q <= FLUSH;
          end else if (issue_ok) begin
            rd_en_q    <= 1'b1;
            rd_last_q  <= (rem_q == LW'(1));
            mem_addr_q <= mem_addr_q + AW'(1);
            rem_q      <= rem_q - LW'(1);
          end
        end
        FILL: begin
          if (rem_q == '0) begin
            mem_wen_q <= 1'b0;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end else begin
            mem_addr_q <= mem_addr_q + AW'(1);
            rem_q      <= rem_q - LW'(1);
          end
        end
        FLUSH: begin
          if (pop && fifo_last_q[rd_ptr_q]) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_last  = (count_q != 2'd0) && fifo_last_q[rd_ptr_q];
endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader: RAM model, shadow memory
// and expected-word queues derived from the command parameters.
module tb_mem_burst_reader;
  localparam int WORDS = 256;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_burst_reader_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus ();

  mem_burst_reader #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [WIDTH-1:0] ram [WORDS];
  logic [WIDTH-1:0] shadow [WORDS];
  bit ram_load = 1'b1;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= WIDTH'(i);
    end else begin
      if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  logic [WIDTH-1:0] dq[$];
  bit               lq[$];
  int               wq[$];
  logic [WIDTH-1:0] fill_exp;
  int               done_cnt = 0;
  bit               stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_data;
  int               rmode = 0;
  int               stall_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.mem_wen) begin
        if (wq.size() == 0) chk("wen_unexpected", 1, 0);
        else begin
          chk("waddr", 32'(bus.mem_addr), 32'(wq.pop_front()));
          chk("wdata", 32'(bus.mem_wdata), 32'(fill_exp));
        end
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (dq.size() == 0) chk("extra_word", 1, 0);
        else begin
          chk("data", 32'(bus.out_data), 32'(dq.pop_front()));
          chk("last", 32'(bus.out_last), 32'(lq.pop_front()));
        end
      end else if (dq.size() == 0) begin
        chk("spurious_valid", 32'(bus.out_valid), 0);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // Mode 0: always ready; 1: random 3-cycle stalls; 2: never ready
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) bus.out_ready = 1'b1;
      else if (rmode == 2) bus.out_ready = 1'b0;
      else if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.out_ready = 1'b0;
        stall_left = 2;
      end else bus.out_ready = 1'b1;
    end
  end

  task automatic run_cmd(input bit o, input int a, input int l,
                         input int fd, input int mode, input bit poke);
    int d0, n, nfv, lat;
    bit seen;
    rmode = mode;
    for (int i = 0; i < l; i++) begin
      int ad = (a + i) % WORDS;
      if (!o) begin
        dq.push_back(shadow[ad]);
        lq.push_back(i == l - 1);
      end else wq.push_back(ad);
    end
    if (o) fill_exp = WIDTH'(fd);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.op         = o;
    bus.start_addr = 8'(a);
    bus.len        = 9'(l);
    bus.fill_data  = WIDTH'(fd);
    n = 0;
    nfv = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        bus.start = 1'b0;
        if (l > 0) chk("first_addr", 32'(bus.mem_addr), 32'(a));
      end
      if (poke && n == 3) begin
        bus.start     = 1'b1;
        bus.op        = 1'b1;
        bus.len       = 9'd5;
        bus.fill_data = 8'h3C;
      end
      if (poke && n == 4) bus.start = 1'b0;
      if (bus.out_valid && nfv == 0) nfv = n;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    if (mode == 0) begin
      lat = (l == 0) ? 2 : (o ? l + 2 : l + 4);
      chk("latency", 32'(n), 32'(lat));
      if (!o && l > 0) chk("first_valid", 32'(nfv), 4);
    end
    @(negedge clk);
    #1;
    chk("busy_after", 32'(bus.busy), 0);
    chk("done_once", 32'(done_cnt - d0), 1);
    chk("drained", 32'(dq.size() + wq.size()), 0);
    if (o) for (int i = 0; i < l; i++) shadow[(a + i) % WORDS] = WIDTH'(fd);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < WORDS; i++) shadow[i] = WIDTH'(i);
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.start_addr = '0;
    bus.len = '0;
    bus.fill_data = '0;
    bus.mem_rdata = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_wen", 32'(bus.mem_wen), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    repeat (3) @(posedge clk);
    ram_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(0, 4, 4, 0, 0, 0);
    run_cmd(0, 254, 4, 0, 0, 0);
    run_cmd(0, 40, 8, 0, 1, 0);
    run_cmd(1, 10, 3, 8'hA5, 0, 0);
    run_cmd(0, 10, 4, 0, 0, 0);
    run_cmd(0, 50, 0, 0, 0, 0);
    run_cmd(1, 60, 0, 8'h11, 0, 0);
    run_cmd(0, 70, 6, 0, 0, 1);
    run_cmd(0, 100, WORDS, 0, 0, 0);
    run_cmd(1, 200, WORDS, 8'h5A, 0, 0);
    run_cmd(0, 7, WORDS, 0, 1, 0);

    // Abort in FLUSH with two words buffered
    rmode = 2;
    for (int i = 0; i < 3; i++) begin
      dq.push_back(shadow[20 + i]);
      lq.push_back(i == 2);
    end
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.start_addr = 8'd20;
    bus.len = 9'd3;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_last", 32'(bus.out_last), 0);
    chk("abort_addr", 32'(bus.mem_addr), 0);
    chk("abort_data", 32'(bus.out_data), 0);
    dq.delete();
    lq.delete();
    rmode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    run_cmd(0, 30, 2, 0, 0, 0);

    for (int k = 0; k < 25; k++) begin
      bit o, pk;
      int a, l, m;
      o  = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, WORDS - 1);
      l  = ($urandom_range(0, 9) == 0) ? WORDS : $urandom_range(0, 12);
      m  = $urandom_range(0, 1);
      pk = !o && l > 0 && ($urandom_range(0, 3) == 0);
      run_cmd(o, a, l, $urandom_range(0, 255), m, pk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameter WORDS, default 256, depth of the attached memory port (power of two).
REQ-002 SHALL have parameter WIDTH, default 8, data word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle command request, sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = read burst to stream, 1 = fill burst.
REQ-007 SHALL have port start_addr  input  $clog2(WORDS)  first memory address.
REQ-008 SHALL have port len  input  $clog2(WORDS)+1  word count, 0..WORDS.
REQ-009 SHALL have port fill_data  input  WIDTH  value written in fill burst, latched at start.
REQ-010 SHALL have port busy  output  1  command in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports mem_addr (output, $clog2(WORDS)), mem_wen (output, 1), mem_wdata (output, WIDTH), all registered: the master side of a single-port RAM with 1-cycle registered read.
REQ-013 SHALL have port mem_rdata  input  WIDTH  RAM read data, valid the cycle after its address was presented.
REQ-014 SHALL have ports out_valid, out_data (WIDTH), out_last (outputs) and out_ready (input): valid/ready stream of read words.

Function
REQ-015 SHALL implement states IDLE, READ, FILL, FLUSH, DONE.
REQ-016 IDLE: start=1, len>0 -> READ (op=0) or FILL (op=1), latching start_addr, len, fill_data; start with len=0 -> DONE, no memory access; start ignored outside IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE, including the DONE cycle.
REQ-018 Addresses SHALL increment by 1 per issued access and wrap modulo WORDS (WORDS-1 -> 0).
REQ-019 READ: read issued by presenting next address on mem_addr with mem_wen=0; exactly len reads per command.
REQ-020 Read data SHALL be captured from mem_rdata the cycle after issue into a 3-entry FIFO driving out_valid/out_data.
REQ-021 Read SHALL issue in a cycle only if registered FIFO count + reads in flight < 3; FIFO never overflows; data never dropped or duplicated.
REQ-022 With out_ready held 1, stream SHALL sustain one word per cycle; start accepted in cycle T -> first address in T+1, first out_valid in T+3.
REQ-023 out_valid/out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_last SHALL be 1 with the len-th word of the command only.
REQ-025 After the last read issues: READ -> FLUSH; FLUSH -> DONE the cycle after the last word handshakes.
REQ-026 FILL: one write per cycle, mem_wen=1, mem_wdata=latched fill_data, len writes; cycle after last write -> DONE; out_valid stays 0.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; a new start is accepted no earlier than the IDLE cycle.
REQ-028 mem_wen SHALL be 0 in every cycle outside FILL.
REQ-029 len=WORDS SHALL access every address exactly once, ending at start_addr-1 modulo WORDS.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, out_valid=0, out_last=0, mem_wen=0, mem_addr=0, mem_wdata=0, out_data=0, FIFO empty, in-flight count 0.
REQ-031 Reset mid-command SHALL abort it with no done pulse; the first command after reset release SHALL behave as from power-up.

Verification
REQ-032 RAM preloaded mem[i]=i; read start_addr=4, len=4, out_ready=1 -> out_data 4,5,6,7 in consecutive cycles from T+3, out_last with 7, done once, busy 0 afterwards.
REQ-033 Read start_addr=254, len=4, WORDS=256 -> mem_addr 254,255,0,1; data 254,255,0,1.
REQ-034 Read len=8, out_ready toggled randomly with 3-cycle stalls -> 8 words in order, no loss or duplication, data stable under stall, at most 3 reads outstanding.
REQ-035 Fill start_addr=10, len=3, fill_data=0xA5 -> mem_wen=1 for 3 cycles at 10,11,12; then read-back shows A5,A5,A5 and mem[13] unchanged.
REQ-036 len=0 -> done pulse the cycle after start, no mem_wen, no out_valid; start pulsed while busy -> ignored.
REQ-037 rst_n low in FLUSH with 2 words buffered -> out_valid=0, busy=0 at once, no done; subsequent read len=2 returns correct data.
